clock: RTL and testbench

- Programmable integer clock divider and tick generator, synchronous to the system clock.
- Produces the game-engine step clock (`clk_out`) plus one-cycle rise/fall strobes and a rising-edge counter.
- Sits at the top level and drives every engine-stepping `always` block.
- The divide ratio is runtime-reloadable and takes effect only at period boundaries, so it never glitches.

---
 rtl/clock_if.sv | 24 ++
 rtl/clock.sv | 86 ++++++++
 tb/tb_clock.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/clock_if.sv
// Control and status bundle of the step-clock divider: enable, ratio reload
// and the divided clock with its strobes and edge counter.
interface clock_if #(
    parameter int DIV_W = 16,
    parameter int CNT_W = 32
);
    logic             en;
    logic [DIV_W-1:0] div;
    logic             div_load;
    logic             clk_out;
    logic             rise_tick;
    logic             fall_tick;
    logic [CNT_W-1:0] edge_count;

    modport master (
        output en, div, div_load,
        input  clk_out, rise_tick, fall_tick, edge_count
    );

    modport slave (
        input  en, div, div_load,
        output clk_out, rise_tick, fall_tick, edge_count
    );
endinterface

// File: rtl/clock.sv
// Programmable integer divider producing the engine step clock, rise/fall
// strobes and a rising-edge counter; ratio changes land only on period wraps.
module clock #(
    parameter int DIV_W     = 16,
    parameter int CNT_W     = 32,
    parameter int RESET_DIV = 4
) (
    input  logic   clk,
    input  logic   rst,
    clock_if.slave bus
);

    function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] v);
        return (v < DIV_W'(2)) ? DIV_W'(2) : v;
    endfunction

    localparam logic [DIV_W-1:0] RESET_N = (RESET_DIV < 2) ? DIV_W'(2) : DIV_W'(RESET_DIV);

    logic [DIV_W-1:0] phase;
    logic [DIV_W-1:0] act_div;
    logic [DIV_W-1:0] pending;
    logic             pending_valid;
    logic             clk_out_q;
    logic             rise_q;
    logic             fall_q;
    logic [CNT_W-1:0] edge_count_q;

    logic             wrap;
    logic [DIV_W-1:0] phase_next;
    logic [DIV_W-1:0] div_next;
    logic [DIV_W:0]   high_len;

    // High length comes from the ratio in force after this edge, so a
    // ratio switch at the wrap shapes the very first cycle of the new period.
    always_comb begin
        wrap       = (phase == act_div - DIV_W'(1));
        phase_next = wrap ? '0 : phase + DIV_W'(1);
        div_next   = act_div;
        if (wrap) begin
            if (bus.div_load)
                div_next = clamp_div(bus.div);
            else if (pending_valid)
                div_next = clamp_div(pending);
        end
        high_len = ({1'b0, div_next} + (DIV_W+1)'(1)) >> 1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            act_div       <= RESET_N;
            phase         <= RESET_N - DIV_W'(1);
            pending       <= '0;
            pending_valid <= 1'b0;
            clk_out_q     <= 1'b0;
            rise_q        <= 1'b0;
            fall_q        <= 1'b0;
            edge_count_q  <= '0;
        end else begin
            if (bus.en) begin
                phase     <= phase_next;
                act_div   <= div_next;
                clk_out_q <= ({1'b0, phase_next} < high_len);
                rise_q    <= wrap;
                fall_q    <= ({1'b0, phase_next} == high_len);
                if (wrap) begin
                    edge_count_q  <= edge_count_q + CNT_W'(1);
                    pending_valid <= 1'b0;
                end
            end else begin
                rise_q <= 1'b0;
                fall_q <= 1'b0;
            end
            // A load that is not consumed by an enabled wrap waits for the next one.
            if (bus.div_load && !(bus.en && wrap)) begin
                pending       <= bus.div;
                pending_valid <= 1'b1;
            end
        end
    end

    assign bus.clk_out    = clk_out_q;
    assign bus.rise_tick  = rise_q;
    assign bus.fall_tick  = fall_q;
    assign bus.edge_count = edge_count_q;

endmodule

// File: tb/tb_clock.sv
// Directed test of the step-clock divider; expected outputs are queued per
// stimulus cycle and compared by an independent monitor on the falling edge.
module tb_clock;

    typedef struct packed {
        int          step;
        logic        clk_out;
        logic        rise;
        logic        fall;
        logic [31:0] count;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    clock_if #(.DIV_W(16), .CNT_W(32)) bus ();

    clock #(.DIV_W(16), .CNT_W(32), .RESET_DIV(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          step   = 0;
    logic [31:0] exp_cnt = '0;

    // ctl = {rst, en, div_load}; expect = {clk_out, rise_tick, fall_tick}.
    // The edge counter expectation follows from the hand-written rise ticks.
    task automatic applyStimulus(input logic [2:0] ctl, input logic [15:0] d,
                                 input logic [2:0] expect_v);
        exp_t e;
        rst          = ctl[2];
        bus.en       = ctl[1];
        bus.div_load = ctl[0];
        bus.div      = d;
        @(posedge clk);
        #1;
        if (ctl[2])
            exp_cnt = '0;
        else if (expect_v[1])
            exp_cnt = exp_cnt + 32'd1;
        step++;
        e.step    = step;
        e.clk_out = expect_v[2];
        e.rise    = expect_v[1];
        e.fall    = expect_v[0];
        e.count   = exp_cnt;
        sb.push_back(e);
    endtask

    task automatic checkOutput(input exp_t e);
        checks++;
        if (bus.clk_out !== e.clk_out) begin
            errors++;
            $display("[TB] FAIL clk_out step %0d: got %b expected %b", e.step, bus.clk_out, e.clk_out);
        end
        checks++;
        if (bus.rise_tick !== e.rise) begin
            errors++;
            $display("[TB] FAIL rise_tick step %0d: got %b expected %b", e.step, bus.rise_tick, e.rise);
        end
        checks++;
        if (bus.fall_tick !== e.fall) begin
            errors++;
            $display("[TB] FAIL fall_tick step %0d: got %b expected %b", e.step, bus.fall_tick, e.fall);
        end
        checks++;
        if (bus.edge_count !== e.count) begin
            errors++;
            $display("[TB] FAIL edge_count step %0d: got %0d expected %0d", e.step, bus.edge_count, e.count);
        end
    endtask

    // Monitor: one queued expectation per clock, compared away from the edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checkOutput(e);
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete, %0d checks, %0d errors", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.en       = 1'b0;
        bus.div      = '0;
        bus.div_load = 1'b0;

        // Reset, also with en and a load asserted (reset dominates, load discarded)
        applyStimulus(3'b100, 16'd0, 3'b000);
        applyStimulus(3'b111, 16'd7, 3'b000);

        // Free run at N=4: 1,1,0,0 with rise on 1,5,9 and fall on 3,7
        applyStimulus(3'b010, 16'd0, 3'b110);
        applyStimulus(3'b010, 16'd0, 3'b100);
        applyStimulus(3'b010, 16'd0, 3'b001);
        applyStimulus(3'b010, 16'd0, 3'b000);
        applyStimulus(3'b010, 16'd0, 3'b110);
        applyStimulus(3'b010, 16'd0, 3'b100);
        applyStimulus(3'b010, 16'd0, 3'b001);
        applyStimulus(3'b010, 16'd0, 3'b000);
        applyStimulus(3'b010, 16'd0, 3'b110);

        // Load 5 mid-period: current /4 period finishes, then 1,1,1,0,0
        applyStimulus(3'b011, 16'd5, 3'b100);
        applyStimulus(3'b010, 16'd0, 3'b001);
        applyStimulus(3'b010, 16'd0, 3'b000);
        applyStimulus(3'b010, 16'd0, 3'b110);
        applyStimulus(3'b010, 16'd0, 3'b100);
        applyStimulus(3'b010, 16'd0, 3'b100);
        applyStimulus(3'b010, 16'd0, 3'b001);
        applyStimulus(3'b010, 16'd0, 3'b000);
        applyStimulus(3'b010, 16'd0, 3'b110);

        // en low for 3 cycles right after a rise: frozen high, no ticks
        applyStimulus(3'b000, 16'd0, 3'b100);
        applyStimulus(3'b000, 16'd0, 3'b100);
        applyStimulus(3'b000, 16'd0, 3'b100);
        applyStimulus(3'b010, 16'd0, 3'b100);
        applyStimulus(3'b010, 16'd0, 3'b100);
        applyStimulus(3'b010, 16'd0, 3'b001);
        applyStimulus(3'b010, 16'd0, 3'b000);
        applyStimulus(3'b010, 16'd0, 3'b110);

        // Load 0 mid-period: clamps to /2 after the /5 period completes
        applyStimulus(3'b011, 16'd0, 3'b100);
        applyStimulus(3'b010, 16'd0, 3'b100);
        applyStimulus(3'b010, 16'd0, 3'b001);
        applyStimulus(3'b010, 16'd0, 3'b000);
        applyStimulus(3'b010, 16'd0, 3'b110);
        applyStimulus(3'b010, 16'd0, 3'b001);
        applyStimulus(3'b010, 16'd0, 3'b110);
        applyStimulus(3'b010, 16'd0, 3'b001);

        // Load 6 then 3 while disabled: last value wins, /3 is 1,1,0
        applyStimulus(3'b001, 16'd6, 3'b000);
        applyStimulus(3'b001, 16'd3, 3'b000);
        applyStimulus(3'b010, 16'd0, 3'b110);
        applyStimulus(3'b010, 16'd0, 3'b100);
        applyStimulus(3'b010, 16'd0, 3'b001);
        applyStimulus(3'b010, 16'd0, 3'b110);
        applyStimulus(3'b010, 16'd0, 3'b100);
        applyStimulus(3'b010, 16'd0, 3'b001);

        // Load 1 on the wrap cycle: applies at once, clamped to /2
        applyStimulus(3'b011, 16'd1, 3'b110);
        applyStimulus(3'b010, 16'd0, 3'b001);
        applyStimulus(3'b010, 16'd0, 3'b110);
        applyStimulus(3'b010, 16'd0, 3'b001);

        // Load 5 on the wrap cycle: the period starting now is already /5
        applyStimulus(3'b011, 16'd5, 3'b110);
        applyStimulus(3'b010, 16'd0, 3'b100);
        applyStimulus(3'b010, 16'd0, 3'b100);
        applyStimulus(3'b010, 16'd0, 3'b001);
        applyStimulus(3'b010, 16'd0, 3'b000);
        applyStimulus(3'b010, 16'd0, 3'b110);
        applyStimulus(3'b010, 16'd0, 3'b100);
        applyStimulus(3'b010, 16'd0, 3'b100);

        // Pending 7 loaded while disabled at phase 2, then reset mid-period
        applyStimulus(3'b001, 16'd7, 3'b100);
        applyStimulus(3'b111, 16'd9, 3'b000);

        // After release: back to /4 (pending 7 was discarded)
        applyStimulus(3'b010, 16'd0, 3'b110);
        applyStimulus(3'b010, 16'd0, 3'b100);
        applyStimulus(3'b010, 16'd0, 3'b001);
        applyStimulus(3'b010, 16'd0, 3'b000);
        applyStimulus(3'b010, 16'd0, 3'b110);

        bus.en       = 1'b0;
        bus.div_load = 1'b0;
        for (int i = 0; i < 4 && sb.size() > 0; i++)
            @(negedge clk);
        @(posedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: got %0d pending expectations, expected 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
